// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_stage_pkg;

    localparam int              ADDR_W       = 16;
    localparam logic [ADDR_W-1:0] RESET_PC   = 16'h0000;
    localparam logic [3:0]      HALT_OPCODE  = 4'hF;
    localparam logic [15:0]     BUBBLE_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HELD,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_e;

    typedef struct packed {
        logic [15:0]       instr;
        logic [ADDR_W-1:0] pc_plus2;
        logic              valid;
    } ifid_t;

    function automatic logic is_halt(input logic [15:0] word);
        return word[15:12] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/cla_16bit.sv
// 16-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum
);
    logic [15:0] p;
    logic [14:0] g;
    logic [15:0] c;

    assign p = a ^ b;
    assign g = a[14:0] & b[14:0];

    for (genvar k = 0; k < 4; k++) begin : g_grp
        localparam int B = 4 * k;
        logic ci;
        if (k == 0) begin : g_first
            assign ci = cin;
        end else begin : g_rest
            assign ci = g[B-1] | (p[B-1] & c[B-1]);
        end
        assign c[B]   = ci;
        assign c[B+1] = g[B] | (p[B] & ci);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & ci);
    end

    assign sum = p ^ c;
endmodule

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register; bubble overrides hold, hold overrides load.
module ifid_reg import fetch_stage_pkg::*; (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  hold,
    input  logic  bubble,
    input  ifid_t d,
    output ifid_t q
);
    ifid_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (bubble) begin
            // pc_plus2 is left alone so decode keeps a sane link value
            q_d.instr = BUBBLE_INSTR;
            q_d.valid = 1'b0;
        end else if (load && !hold) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '{instr: BUBBLE_INSTR, pc_plus2: '0, valid: 1'b0};
        else        q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, single-outstanding icache request, skid
// buffer for a word returned under stall, and the IF/ID register.
module fetch_stage import fetch_stage_pkg::*; (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              pc_redirect,
    input  logic              stall,
    input  logic [15:0]       icache_data,
    input  logic              icache_valid,
    output logic              icache_req,
    output logic [ADDR_W-1:0] icache_addr,
    output logic [ADDR_W-1:0] pc_cur,
    output logic [15:0]       ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc_plus2,
    output logic              ifid_valid,
    output logic              fetch_busy,
    output logic              halted
);
    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, req_addr_q, req_addr_d, req_plus2;
    logic [15:0]       buf_q, buf_d;
    logic              ifid_load, ifid_hold, ifid_bubble;
    ifid_t             ifid_d, ifid_q;
    logic              word_hlt, buf_hlt;

    assign word_hlt = is_halt(icache_data);
    assign buf_hlt  = is_halt(buf_q);

    cla_16bit u_inc (.a(req_addr_q), .b(16'h0002), .cin(1'b0), .sum(req_plus2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (icache_valid) begin
                    if (pc_redirect)   state_d = ST_FETCH;
                    else if (stall)    state_d = ST_HELD;
                    else if (word_hlt) state_d = ST_HALTED;
                end else if (pc_redirect) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HELD: begin
                if (pc_redirect) state_d = ST_FETCH;
                else if (!stall) state_d = buf_hlt ? ST_HALTED : ST_FETCH;
            end
            ST_DRAIN:  if (icache_valid) state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_d       = buf_q;
        ifid_load   = 1'b0;
        ifid_hold   = 1'b0;
        ifid_bubble = 1'b0;
        ifid_d      = '{instr: (state_q == ST_HELD) ? buf_q : icache_data,
                        pc_plus2: req_plus2, valid: 1'b1};
        case (state_q)
            ST_IDLE: begin
                req_addr_d  = pc_q;
                ifid_bubble = !stall;
            end
            ST_FETCH: begin
                if (icache_valid && pc_redirect) begin
                    pc_d        = next_pc;
                    req_addr_d  = next_pc;
                    ifid_bubble = 1'b1;
                end else if (icache_valid && stall) begin
                    buf_d     = icache_data;
                    ifid_hold = 1'b1;
                end else if (icache_valid) begin
                    ifid_load = 1'b1;
                    if (!word_hlt) begin
                        pc_d       = next_pc;
                        req_addr_d = next_pc;
                    end
                end else if (pc_redirect) begin
                    // old request stays on the bus until its word comes back
                    pc_d        = next_pc;
                    ifid_bubble = 1'b1;
                end else begin
                    ifid_bubble = !stall;
                    ifid_hold   = stall;
                end
            end
            ST_HELD: begin
                if (pc_redirect) begin
                    pc_d        = next_pc;
                    req_addr_d  = next_pc;
                    ifid_bubble = 1'b1;
                end else if (stall) begin
                    ifid_hold = 1'b1;
                end else begin
                    ifid_load = 1'b1;
                    if (!buf_hlt) begin
                        pc_d       = next_pc;
                        req_addr_d = next_pc;
                    end
                end
            end
            ST_DRAIN: begin
                if (pc_redirect) begin
                    pc_d        = next_pc;
                    ifid_bubble = 1'b1;
                    if (icache_valid) req_addr_d = next_pc;
                end else begin
                    if (icache_valid) req_addr_d = pc_q;
                    ifid_bubble = !stall;
                    ifid_hold   = stall;
                end
            end
            default: begin
                ifid_bubble = !stall;
                ifid_hold   = stall;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            buf_q      <= BUBBLE_INSTR;
        end else begin
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            buf_q      <= buf_d;
        end
    end

    ifid_reg u_ifid (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (ifid_load),
        .hold   (ifid_hold),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    always_comb begin
        icache_req = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
        fetch_busy = icache_req && !icache_valid;
        halted     = (state_q == ST_HALTED);
    end

    assign icache_addr   = req_addr_q;
    assign pc_cur        = pc_q;
    assign ifid_instr    = ifid_q.instr;
    assign ifid_pc_plus2 = ifid_q.pc_plus2;
    assign ifid_valid    = ifid_q.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, hits, miss+stall, drain, halt, wrap.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] next_pc;
    logic        pc_redirect, stall, icache_valid;
    logic [15:0] icache_data;
    logic        icache_req, ifid_valid, fetch_busy, halted;
    logic [15:0] icache_addr, pc_cur, ifid_instr, ifid_pc_plus2;
    int          nchecks = 0;
    int          nerrors = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .next_pc       (next_pc),
        .pc_redirect   (pc_redirect),
        .stall         (stall),
        .icache_data   (icache_data),
        .icache_valid  (icache_valid),
        .icache_req    (icache_req),
        .icache_addr   (icache_addr),
        .pc_cur        (pc_cur),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .fetch_busy    (fetch_busy),
        .halted        (halted)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // one rising edge, then land on the falling edge for checks/new inputs
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; next_pc = 16'h0000; pc_redirect = 1'b0; stall = 1'b0;
        icache_data = 16'h0000; icache_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_req",    icache_req,    1'b0);
        chk1("rst_busy",   fetch_busy,    1'b0);
        chk1("rst_halted", halted,        1'b0);
        chk ("rst_pc",     pc_cur,        16'h0000);
        chk1("rst_ifid_v", ifid_valid,    1'b0);
        chk ("rst_pc2",    ifid_pc_plus2, 16'h0000);

        rst_n = 1'b1; tick();
        chk1("first_req",  icache_req,  1'b1);
        chk ("first_addr", icache_addr, 16'h0000);
        chk1("first_busy", fetch_busy,  1'b1);
        tick();
        // reset in the middle of a miss, with the response arriving during reset
        rst_n = 1'b0; icache_valid = 1'b1; icache_data = 16'h1234; #1;
        chk1("midrst_req",  icache_req, 1'b0);
        chk ("midrst_pc",   pc_cur,     16'h0000);
        chk1("midrst_busy", fetch_busy, 1'b0);
        tick();
        chk1("midrst_ifid_v", ifid_valid, 1'b0);
        icache_valid = 1'b0; rst_n = 1'b1; tick();
        chk1("rel_req",  icache_req,  1'b1);
        chk ("rel_addr", icache_addr, 16'h0000);

        icache_valid = 1'b1; icache_data = 16'h1111; next_pc = 16'h0002; tick();
        chk ("hit1_instr", ifid_instr,    16'h1111);
        chk ("hit1_pc2",   ifid_pc_plus2, 16'h0002);
        chk1("hit1_v",     ifid_valid,    1'b1);
        chk ("hit1_addr",  icache_addr,   16'h0002);
        icache_data = 16'h2222; next_pc = 16'h0004; tick();
        chk ("hit2_instr", ifid_instr,    16'h2222);
        chk ("hit2_pc2",   ifid_pc_plus2, 16'h0004);
        icache_data = 16'h3333; next_pc = 16'h0006; tick();
        chk ("hit3_instr", ifid_instr,    16'h3333);
        chk ("hit3_pc2",   ifid_pc_plus2, 16'h0006);
        chk ("hit3_pc",    pc_cur,        16'h0006);

        icache_valid = 1'b0; tick();
        chk1("miss1_v",     ifid_valid,    1'b0);
        chk ("miss1_instr", ifid_instr,    16'h0000);
        chk ("miss1_pc2",   ifid_pc_plus2, 16'h0006);
        chk1("miss1_busy",  fetch_busy,    1'b1);
        tick(); tick();
        chk1("miss3_v",    ifid_valid,  1'b0);
        chk ("miss3_addr", icache_addr, 16'h0006);
        icache_valid = 1'b1; icache_data = 16'h4444; stall = 1'b1; next_pc = 16'h0008; tick();
        icache_valid = 1'b0; #1;
        chk1("held_req",  icache_req, 1'b0);
        chk1("held_busy", fetch_busy, 1'b0);
        chk1("held_v",    ifid_valid, 1'b0);
        chk ("held_pc",   pc_cur,     16'h0006);
        tick();
        chk1("held2_req", icache_req, 1'b0);
        stall = 1'b0; tick();
        chk ("unheld_instr", ifid_instr,    16'h4444);
        chk ("unheld_pc2",   ifid_pc_plus2, 16'h0008);
        chk1("unheld_v",     ifid_valid,    1'b1);
        chk1("unheld_req",   icache_req,    1'b1);
        chk ("unheld_addr",  icache_addr,   16'h0008);

        pc_redirect = 1'b1; next_pc = 16'h0040; tick();
        pc_redirect = 1'b0; next_pc = 16'h0042;
        chk ("drain_pc",   pc_cur,      16'h0040);
        chk ("drain_addr", icache_addr, 16'h0008);
        chk1("drain_req",  icache_req,  1'b1);
        chk1("drain_v",    ifid_valid,  1'b0);
        chk1("drain_busy", fetch_busy,  1'b1);
        tick();
        icache_valid = 1'b1; icache_data = 16'h5555; #1;
        chk1("drain_vbusy", fetch_busy, 1'b0);
        tick();
        icache_valid = 1'b0;
        chk ("postdrain_addr",  icache_addr, 16'h0040);
        chk1("postdrain_v",     ifid_valid,  1'b0);
        chk ("postdrain_instr", ifid_instr,  16'h0000);

        icache_valid = 1'b1; icache_data = 16'h6666; pc_redirect = 1'b1; next_pc = 16'h0040; tick();
        pc_redirect = 1'b0;
        chk1("rdv_v",     ifid_valid,  1'b0);
        chk ("rdv_instr", ifid_instr,  16'h0000);
        chk ("rdv_addr",  icache_addr, 16'h0040);
        chk ("rdv_pc",    pc_cur,      16'h0040);
        icache_data = 16'hF000; next_pc = 16'h0042; tick();
        icache_valid = 1'b0;
        chk ("hlt_instr",  ifid_instr,    16'hF000);
        chk ("hlt_pc2",    ifid_pc_plus2, 16'h0042);
        chk1("hlt_v",      ifid_valid,    1'b1);
        chk1("hlt_halted", halted,        1'b1);
        chk1("hlt_req",    icache_req,    1'b0);
        chk ("hlt_pc",     pc_cur,        16'h0040);
        tick();
        chk1("hlt2_v",      ifid_valid, 1'b0);
        chk1("hlt2_req",    icache_req, 1'b0);
        chk ("hlt2_pc",     pc_cur,     16'h0040);
        chk1("hlt2_halted", halted,     1'b1);

        rst_n = 1'b0; #1;
        chk1("rst2_halted", halted,        1'b0);
        chk ("rst2_pc2",    ifid_pc_plus2, 16'h0000);
        tick();
        rst_n = 1'b1; tick();
        icache_valid = 1'b1; icache_data = 16'h7777; next_pc = 16'hFFFE; tick();
        chk ("wrap_addr", icache_addr,   16'hFFFE);
        chk ("wrap_pc2a", ifid_pc_plus2, 16'h0002);
        icache_data = 16'h8888; next_pc = 16'h0000; tick();
        chk ("wrap_instr", ifid_instr,    16'h8888);
        chk ("wrap_pc2",   ifid_pc_plus2, 16'h0000);
        chk1("wrap_v",     ifid_valid,    1'b1);
        icache_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 16-bit pipelined core. It owns the PC register and presents the current PC to the PC control block, then loads that block's next-PC result. It issues single-outstanding requests to the instruction cache, tolerates multi-cycle misses, and loads the IF/ID pipeline register. The IF/ID register supports hold (stall), bubble (flush/miss) and permanent stop on a HLT opcode.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset
- HALT_OPCODE, 4'hF, instr[15:12] value that stops fetch
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- next_pc  in  16  next fetch address from PC control (PC+2 or taken-branch target)
- pc_redirect  in  1  taken branch resolved in decode; flush wrong-path fetch
- stall  in  1  hazard-unit stall of decode; hold IF/ID and PC
- icache_data  in  16  instruction word, valid with icache_valid
- icache_valid  in  1  one-cycle pulse completing the outstanding request
- icache_req  out  1  request active at icache_addr
- icache_addr  out  16  registered request address (req_addr)
- pc_cur  out  16  PC register, to PC control
- ifid_instr  out  16  IF/ID instruction
- ifid_pc_plus2  out  16  IF/ID fetch address + 2
- ifid_valid  out  1  IF/ID holds a real instruction
- fetch_busy  out  1  request outstanding, no data this cycle
- halted  out  1  HLT accepted; fetch stopped until reset

## Operation
- States: IDLE, FETCH, HELD, DRAIN, HALTED.
- icache_req = 1 in FETCH and DRAIN only.
- icache_addr = req_addr, held stable while the request is outstanding.
- IDLE: req_addr <= PC; go to FETCH.
- FETCH with valid and redirect: drop the word; PC and req_addr <= next_pc; IF/ID <= bubble; stay in FETCH.
- FETCH with valid, no stall: IF/ID <= {word, req_addr+2, valid=1}; PC and req_addr <= next_pc.
  - If word[15:12] == HALT_OPCODE: go to HALTED and do not update PC.
  - Otherwise stay in FETCH.
- FETCH with valid and stall: word goes to the skid buffer; IF/ID held; go to HELD.
- FETCH, no valid, redirect: PC <= next_pc; IF/ID <= bubble; go to DRAIN.
- FETCH, no valid, otherwise: IF/ID <= bubble if no stall, held if stall.
- HELD: icache_req = 0.
  - redirect: discard the buffer; PC and req_addr <= next_pc; IF/ID <= bubble; go to FETCH.
  - no stall: buffer moves to IF/ID; PC and req_addr <= next_pc; go to FETCH. A HLT word goes to HALTED instead.
  - stall: hold everything.
- DRAIN: the old request is still outstanding.
  - On valid: discard the word; req_addr <= PC; go to FETCH.
  - A further redirect in DRAIN: PC <= next_pc; stay in DRAIN.
- HALTED: absorbing. No requests; PC frozen; IF/ID <= bubble whenever stall = 0. Leaves only on reset.
- Bubble: ifid_instr = 16'h0000, ifid_valid = 0; ifid_pc_plus2 unchanged.
- Priority: redirect > stall. redirect together with stall is treated as redirect.
- Arithmetic: req_addr+2 is modulo 2^16; 16'hFFFE + 2 = 16'h0000. No exception is raised.
- fetch_busy = (FETCH or DRAIN) and ~icache_valid.
- halted = (state == HALTED).

## Timing
- Reset (async, any state, mid-miss included): state IDLE, PC = req_addr = RESET_PC, IF/ID bubble with ifid_pc_plus2 = 0, buffer cleared.
- Output values during reset: icache_req = 0, fetch_busy = 0, halted = 0.
- A cache response pending at reset is ignored; a valid arriving in IDLE is discarded.
- First request: cycle 1 after rst_n rises (IDLE -> FETCH).
- Cache contract: icache_valid comes at earliest 1 cycle after req/addr are presented. Holding req high back-to-back starts a new request at the new address.
- Hit every cycle: one instruction into IF/ID per cycle; IF/ID updated on the valid edge, so latency is 1 edge.
- Miss of N cycles: N bubbles into IF/ID (if no stall).
- Redirect with no valid pending: one bubble, plus DRAIN cycles until the old valid arrives. The new request starts the cycle after the discarded valid.

## Structure
- Shared package holds:
  - state enum
  - HALT_OPCODE
  - bubble instruction constant
  - 16-bit address width constant
- Sub-module `ifid_reg`: 16+16+1 register with load, hold and bubble controls (bubble > hold), async active-low reset.
- The +2 incrementer reuses the existing `cla_16bit` (Cin = 0, B = 16'h2).

## Test plan
- Reset mid-miss: rst_n low while req outstanding, valid arrives during reset → valid ignored; icache_req = 0, PC = 0000; after release, first req at 0000 one cycle later.
- Hits every cycle, next_pc = PC+2, words 1111/2222/3333 → IF/ID shows those words on consecutive edges; ifid_pc_plus2 = 0002/0004/0006.
- 3-cycle miss, then stall held 2 cycles on the valid edge → 3 bubbles; word buffered in HELD with icache_req = 0; word enters IF/ID the edge after stall drops.
- Redirect with no valid pending, next_pc = 0040 → DRAIN; the late old word is discarded; next req_addr = 0040; IF/ID never shows the old word.
- Redirect coincident with valid, then HLT word F000 fetched at 0040 → first word dropped; F000 loaded into IF/ID; halted = 1; icache_req = 0 thereafter; PC stays 0040.
- Wrap: PC = FFFE hit → ifid_pc_plus2 = 0000.
